// File: rtl/hazard_unit.sv
// Stall/forward scheduler for a 5-stage MIPS pipeline. Tracks dest/Tnew of the
// instructions in E, M and W and derives the D-stage stall and all bypass selects.
module hazard_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned TW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic [TW-1:0]     tuse_rs_D,
  input  logic [TW-1:0]     tuse_rt_D,
  input  logic [REG_AW-1:0] wa_D,
  input  logic [TW-1:0]     tnew_D,
  output logic              stall,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [1:0]        fwd_rs_E,
  output logic [1:0]        fwd_rt_E,
  output logic [1:0]        fwd_rt_M
);

  localparam logic [TW-1:0] TuseNone = {TW{1'b1}};

  logic [REG_AW-1:0] rs_e_q, rt_e_q, wa_e_q;
  logic [TW-1:0]     tnew_e_q;
  logic [REG_AW-1:0] rt_m_q, wa_m_q;
  logic [TW-1:0]     tnew_m_q;
  logic [REG_AW-1:0] wa_w_q;

  logic hz_rs, hz_rt;

  function automatic logic hazard(input logic [REG_AW-1:0] r, input logic [TW-1:0] tu,
                                  input logic [REG_AW-1:0] wa_e, input logic [TW-1:0] tn_e,
                                  input logic [REG_AW-1:0] wa_m, input logic [TW-1:0] tn_m);
    return (r != '0) && (tu != TuseNone) &&
           (((r == wa_e) && (tn_e > tu)) || ((r == wa_m) && (tn_m > tu)));
  endfunction

  // Nearest producer wins; if it is not ready yet the select stays 0.
  function automatic logic [1:0] fwd_d(input logic [REG_AW-1:0] r,
                                       input logic [REG_AW-1:0] wa_e, input logic [TW-1:0] tn_e,
                                       input logic [REG_AW-1:0] wa_m, input logic [TW-1:0] tn_m,
                                       input logic [REG_AW-1:0] wa_w);
    logic [1:0] sel;
    sel = 2'd0;
    if (r != '0) begin
      if (r == wa_e)      sel = (tn_e == '0) ? 2'd1 : 2'd0;
      else if (r == wa_m) sel = (tn_m == '0) ? 2'd2 : 2'd0;
      else if (r == wa_w) sel = 2'd3;
    end
    return sel;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] r,
                                       input logic [REG_AW-1:0] wa_m, input logic [TW-1:0] tn_m,
                                       input logic [REG_AW-1:0] wa_w);
    logic [1:0] sel;
    sel = 2'd0;
    if (r != '0) begin
      if ((r == wa_m) && (tn_m == '0)) sel = 2'd2;
      else if (r == wa_w)              sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    hz_rs    = hazard(rs_D, tuse_rs_D, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q);
    hz_rt    = hazard(rt_D, tuse_rt_D, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q);
    stall    = hz_rs | hz_rt;
    fwd_rs_D = fwd_d(rs_D, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q, wa_w_q);
    fwd_rt_D = fwd_d(rt_D, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q, wa_w_q);
    fwd_rs_E = fwd_e(rs_e_q, wa_m_q, tnew_m_q, wa_w_q);
    fwd_rt_E = fwd_e(rt_e_q, wa_m_q, tnew_m_q, wa_w_q);
    fwd_rt_M = ((rt_m_q != '0) && (rt_m_q == wa_w_q)) ? 2'd3 : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_e_q   <= '0;
      rt_e_q   <= '0;
      wa_e_q   <= '0;
      tnew_e_q <= '0;
      rt_m_q   <= '0;
      wa_m_q   <= '0;
      tnew_m_q <= '0;
      wa_w_q   <= '0;
    end else begin
      rt_m_q   <= rt_e_q;
      wa_m_q   <= wa_e_q;
      tnew_m_q <= (tnew_e_q == '0) ? '0 : tnew_e_q - 1'b1;
      wa_w_q   <= wa_m_q;
      if (stall) begin
        rs_e_q   <= '0;
        rt_e_q   <= '0;
        wa_e_q   <= '0;
        tnew_e_q <= '0;
      end else begin
        rs_e_q   <= rs_D;
        rt_e_q   <= rt_D;
        wa_e_q   <= wa_D;
        tnew_e_q <= tnew_D;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a history-based pipeline model predicts each
// cycle's outputs; a negedge monitor pops and compares them.
module tb_hazard_unit;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tus;
    logic [1:0] tut;
    logic [4:0] wa;
    logic [1:0] tn;
  } instr_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] rsd;
    logic [1:0] rtd;
    logic [1:0] rse;
    logic [1:0] rte;
    logic [1:0] rtm;
  } exp_t;

  logic       clk, reset;
  logic [4:0] rs_D, rt_D, wa_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
  logic       stall;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;

  hazard_unit #(.REG_AW(5), .TW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rs_D      (rs_D),
    .rt_D      (rt_D),
    .tuse_rs_D (tuse_rs_D),
    .tuse_rt_D (tuse_rt_D),
    .wa_D      (wa_D),
    .tnew_D    (tnew_D),
    .stall     (stall),
    .fwd_rs_D  (fwd_rs_D),
    .fwd_rt_D  (fwd_rt_D),
    .fwd_rs_E  (fwd_rs_E),
    .fwd_rt_E  (fwd_rt_E),
    .fwd_rt_M  (fwd_rt_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hist[0] is the instruction now in E, hist[1] in M, hist[2] in W.
  instr_t hist[3];
  exp_t   exp_q[$];
  int     n_chk = 0;
  int     n_pass = 0;

  function automatic int remaining(int k);
    return (int'(hist[k].tn) > k) ? int'(hist[k].tn) - k : 0;
  endfunction

  function automatic logic m_hazard(logic [4:0] r, logic [1:0] tu);
    if (r == 0 || tu == 2'd3) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (hist[k].wa == r && remaining(k) > int'(tu)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_fwd_d(logic [4:0] r);
    if (r == 0) return 2'd0;
    for (int k = 0; k < 3; k++)
      if (hist[k].wa == r) return (k == 2 || remaining(k) == 0) ? 2'(k + 1) : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_fwd_e(logic [4:0] r);
    if (r == 0) return 2'd0;
    if (hist[1].wa == r && remaining(1) == 0) return 2'd2;
    if (hist[2].wa == r) return 2'd3;
    return 2'd0;
  endfunction

  function automatic instr_t mk(int rs, int rt, int tus, int tut, int wa, int tn);
    instr_t i;
    i.rs = 5'(rs); i.rt = 5'(rt); i.tus = 2'(tus); i.tut = 2'(tut);
    i.wa = 5'(wa); i.tn = 2'(tn);
    return i;
  endfunction

  task automatic step(input instr_t d, input logic rst, output logic st);
    exp_t e;
    rs_D = d.rs; rt_D = d.rt; tuse_rs_D = d.tus; tuse_rt_D = d.tut;
    wa_D = d.wa; tnew_D = d.tn; reset = rst;
    e.stall = m_hazard(d.rs, d.tus) | m_hazard(d.rt, d.tut);
    e.rsd   = m_fwd_d(d.rs);
    e.rtd   = m_fwd_d(d.rt);
    e.rse   = m_fwd_e(hist[0].rs);
    e.rte   = m_fwd_e(hist[0].rt);
    e.rtm   = (hist[1].rt != 0 && hist[1].rt == hist[2].wa) ? 2'd3 : 2'd0;
    exp_q.push_back(e);
    st = e.stall;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 0; k < 3; k++) hist[k] = '0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = e.stall ? instr_t'('0) : d;
    end
    reset = 1'b0;
  endtask

  // Holds the instruction in D for as long as the model predicts a stall.
  task automatic issue(input instr_t d);
    logic st;
    int   n;
    n = 0;
    do begin
      step(d, 1'b0, st);
      n++;
    end while (st && n < 8);
  endtask

  task automatic drain();
    repeat (3) issue(mk(0, 0, 3, 3, 0, 0));
  endtask

  task automatic cmp(input string name, input logic [1:0] got, input logic [1:0] want);
    n_chk++;
    if (got !== want) $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    else n_pass++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp("stall",    {1'b0, stall}, {1'b0, e.stall});
        cmp("fwd_rs_D", fwd_rs_D, e.rsd);
        cmp("fwd_rt_D", fwd_rt_D, e.rtd);
        cmp("fwd_rs_E", fwd_rs_E, e.rse);
        cmp("fwd_rt_E", fwd_rt_E, e.rte);
        cmp("fwd_rt_M", fwd_rt_M, e.rtm);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    logic st;
    instr_t nop, d;
    nop = mk(0, 0, 3, 3, 0, 0);
    rs_D = '0; rt_D = '0; wa_D = '0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; tnew_D = '0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) hist[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    step(nop, 1'b0, st);                          // state straight after reset
    // addu $1,$2,$3 ; addu $4,$1,$5
    issue(mk(2, 3, 1, 1, 1, 1)); issue(mk(1, 5, 1, 1, 4, 1)); drain();
    // lw $2 ; addu $3,$2,$2
    issue(mk(0, 0, 1, 3, 2, 2)); issue(mk(2, 2, 1, 1, 3, 1)); drain();
    // lw $2 ; beq $2,$0
    issue(mk(0, 0, 1, 3, 2, 2)); issue(mk(2, 0, 0, 0, 0, 0)); drain();
    // jal ; jr $31
    issue(mk(0, 0, 3, 3, 31, 0)); issue(mk(31, 0, 0, 3, 0, 0)); drain();
    // lw $0 ; beq $0,$0
    issue(mk(0, 0, 1, 3, 0, 2)); issue(mk(0, 0, 0, 0, 0, 0)); drain();
    // lw $4 ; sw $4,0($1)
    issue(mk(0, 0, 1, 3, 4, 2)); issue(mk(1, 4, 1, 2, 0, 0)); drain();
    // reset asserted while lw ; beq is stalling
    issue(mk(0, 0, 1, 3, 2, 2));
    step(mk(2, 0, 0, 0, 0, 0), 1'b0, st);
    step(mk(2, 0, 0, 0, 0, 0), 1'b1, st);
    step(nop, 1'b0, st);
    drain();

    for (int n = 0; n < 400; n++) begin
      d = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2));
      if ($urandom_range(0, 49) == 0) step(d, 1'b1, st);
      else issue(d);
    end
    drain();

    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
